// File: rtl/cmd_pkg.sv
// Shared constants for the timestamped command dispatcher: opcodes, header field
// positions, reply prefixes and FSM state encoding.
package cmd_pkg;

  localparam logic [7:0] OpPing        = 8'd0;
  localparam logic [7:0] OpPingReply   = 8'd1;
  localparam logic [7:0] OpWrite       = 8'd2;
  localparam logic [7:0] OpWriteMasked = 8'd3;
  localparam logic [7:0] OpRead        = 8'd4;
  localparam logic [7:0] OpReadReply   = 8'd5;
  localparam logic [7:0] OpDelay       = 8'd12;

  localparam int unsigned HdrPayloadLsb = 2;
  localparam int unsigned HdrChanLsb    = 16;
  localparam int unsigned HdrChanW      = 5;
  localparam int unsigned OpcodeLsb     = 24;

  // A timestamp of all ones means "execute as soon as possible".
  localparam logic [31:0] TsImmediate = 32'hFFFF_FFFF;

  localparam logic [15:0] RplPing = {OpPingReply, 8'd2};
  localparam logic [15:0] RplRead = {OpReadReply, 8'd6};

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StTs,
    StWait,
    StFetch,
    StWrOp,
    StWmVal,
    StWmMask,
    StRdReq,
    StRdWait,
    StWmWr,
    StDly,
    StSend,
    StDrop
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cmd_time_cmp.sv
// Wrap-safe execute-window compare: go when the timestamp is 1..JITTER ticks ahead
// (or immediate), late when it is now or in the past; otherwise keep waiting.
module cmd_time_cmp
  import cmd_pkg::*;
#(
  parameter int unsigned JITTER = 5
) (
  input  logic [31:0] ts_i,
  input  logic [31:0] adc_time_i,
  output logic        go_o,
  output logic        late_o
);

  logic [31:0] diff;

  always_comb begin
    diff   = ts_i - adc_time_i;
    go_o   = (ts_i == TsImmediate) || ((diff != 32'd0) && (diff <= JITTER));
    late_o = !go_o && ((diff == 32'd0) || diff[31]);
  end

endmodule

// File: rtl/cmd_dispatch_mc.sv
// Timestamped command dispatcher: pops command packets, waits for their time window,
// executes them on a multi-channel register bus and streams replies.
// Optional statistics counters are built when CMD_STATS_EN is defined.
module cmd_dispatch_mc
  import cmd_pkg::*;
#(
  parameter int unsigned NUM_CHAN   = 4,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned JITTER     = 5,
  parameter int unsigned PAYLOAD_W  = 7,
  parameter int unsigned REG_RD_LAT = 1,
  localparam int unsigned CHAN_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic              txclk,
  input  logic              reset,
  input  logic [31:0]       adc_time,
  input  logic              pkt_waiting,
  input  logic [31:0]       fifodata,
  output logic              rdreq,
  output logic              skip,
  input  logic              rx_WR_enabled,
  output logic [15:0]       rx_databus,
  output logic              rx_WR,
  output logic              rx_WR_done,
  output logic [CHAN_W-1:0] reg_chan,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [31:0]       reg_rdata,
  output logic              stop,
  output logic [15:0]       stop_time
`ifdef CMD_STATS_EN
  ,
  output logic [15:0]       stat_exec,
  output logic [15:0]       stat_late,
  output logic [15:0]       stat_err
`endif
);

  typedef logic [PAYLOAD_W:0] pext_t;
  localparam logic [2:0] RdLat = 3'(REG_RD_LAT);

  state_e                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [PAYLOAD_W-1:0]   words_q, words_d;
  logic [HdrChanW-1:0]    chan_q, chan_d;
  logic [31:0]            ts_q, ts_d;
  logic [7:0]             op_q, op_d;
  logic [15:0]            opw_q, opw_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [31:0]            val_q, val_d;
  logic [31:0]            mask_q, mask_d;
  logic                   rd_busy_q, rd_busy_d;
  logic [2:0]             rd_cnt_q, rd_cnt_d;
  logic [31:0]            rd_data_q, rd_data_d;
  logic                   replied_q, replied_d;
  logic [1:0]             idx_q, idx_d;
  logic [15:0]            stop_time_q, stop_time_d;

  logic       t_go, t_late;
  logic [7:0] opcode;
  logic [1:0] nops;
  logic       trunc;
  logic       last_word;
  logic [15:0] rpl_word;

  cmd_time_cmp #(
    .JITTER(JITTER)
  ) u_time_cmp (
    .ts_i      (ts_q),
    .adc_time_i(adc_time),
    .go_o      (t_go),
    .late_o    (t_late)
  );

  assign reg_chan  = chan_q[CHAN_W-1:0];
  assign reg_addr  = addr_q;
  assign stop_time = stop_time_q;

  // Operand count and truncation check are resolved while the opcode is popped,
  // so a short packet never produces a register strobe.
  always_comb begin
    opcode = fifodata[OpcodeLsb +: 8];
    unique case (opcode)
      OpWrite:       nops = 2'd1;
      OpWriteMasked: nops = 2'd2;
      default:       nops = 2'd0;
    endcase
    trunc = (pext_t'(words_q) + pext_t'(nops) + pext_t'(1)) > pext_t'(payload_q);
  end

  always_comb begin
    last_word = (op_q == OpPing) ? (idx_q == 2'd1) : (idx_q == 2'd3);
    unique case (idx_q)
      2'd0:    rpl_word = (op_q == OpPing) ? RplPing : RplRead;
      2'd1:    rpl_word = opw_q;
      2'd2:    rpl_word = rd_data_q[31:16];
      default: rpl_word = rd_data_q[15:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    words_d     = words_q;
    chan_d      = chan_q;
    ts_d        = ts_q;
    op_d        = op_q;
    opw_d       = opw_q;
    addr_d      = addr_q;
    val_d       = val_q;
    mask_d      = mask_q;
    rd_busy_d   = rd_busy_q;
    rd_cnt_d    = rd_cnt_q;
    rd_data_d   = rd_data_q;
    replied_d   = replied_q;
    idx_d       = idx_q;
    stop_time_d = stop_time_q;
    rdreq       = 1'b0;
    skip        = 1'b0;
    rx_WR       = 1'b0;
    rx_WR_done  = 1'b0;
    rx_databus  = 16'd0;
    reg_we      = 1'b0;
    reg_re      = 1'b0;
    reg_wdata   = 32'd0;
    stop        = 1'b0;

    // Read-data capture runs beside the FSM so operand pops overlap the latency.
    if (rd_busy_q) begin
      if (rd_cnt_q == RdLat) begin
        rd_data_d = reg_rdata;
        rd_busy_d = 1'b0;
      end else begin
        rd_cnt_d = rd_cnt_q + 3'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pkt_waiting) state_d = StHdr;
      end
      StHdr: begin
        rdreq     = 1'b1;
        payload_d = fifodata[HdrPayloadLsb +: PAYLOAD_W];
        chan_d    = fifodata[HdrChanLsb +: HdrChanW];
        words_d   = '0;
        replied_d = 1'b0;
        state_d   = StTs;
      end
      StTs: begin
        rdreq   = 1'b1;
        ts_d    = fifodata;
        state_d = (32'(chan_q) >= NUM_CHAN) ? StDrop : StWait;
      end
      StWait: begin
        if (t_go) begin
          state_d = StFetch;
        end else if (t_late) begin
          state_d = StDrop;
        end
      end
      StFetch: begin
        if (words_q == payload_q) begin
          skip       = 1'b1;
          rx_WR_done = replied_q;
          state_d    = StIdle;
        end else begin
          rdreq   = 1'b1;
          words_d = words_q + 1'b1;
          op_d    = opcode;
          opw_d   = fifodata[15:0];
          idx_d   = 2'd0;
          if (trunc) begin
            state_d = StDrop;
          end else begin
            case (opcode)
              OpPing:        state_d = StSend;
              OpWrite:       begin addr_d = fifodata[ADDR_W-1:0]; state_d = StWrOp;  end
              OpWriteMasked: begin addr_d = fifodata[ADDR_W-1:0]; state_d = StWmVal; end
              OpRead:        begin addr_d = fifodata[ADDR_W-1:0]; state_d = StRdReq; end
              OpDelay:       begin stop_time_d = fifodata[15:0];  state_d = StDly;   end
              default:       state_d = StDrop;
            endcase
          end
        end
      end
      StWrOp: begin
        rdreq     = 1'b1;
        words_d   = words_q + 1'b1;
        reg_we    = 1'b1;
        reg_wdata = fifodata;
        state_d   = StFetch;
      end
      StWmVal: begin
        rdreq     = 1'b1;
        words_d   = words_q + 1'b1;
        val_d     = fifodata;
        reg_re    = 1'b1;
        rd_busy_d = 1'b1;
        rd_cnt_d  = 3'd1;
        state_d   = StWmMask;
      end
      StWmMask: begin
        rdreq   = 1'b1;
        words_d = words_q + 1'b1;
        mask_d  = fifodata;
        state_d = StRdWait;
      end
      StRdReq: begin
        reg_re    = 1'b1;
        rd_busy_d = 1'b1;
        rd_cnt_d  = 3'd1;
        state_d   = StRdWait;
      end
      StRdWait: begin
        if (!rd_busy_q) state_d = (op_q == OpRead) ? StSend : StWmWr;
      end
      StWmWr: begin
        reg_we    = 1'b1;
        reg_wdata = (rd_data_q & ~mask_q) | (val_q & mask_q);
        state_d   = StFetch;
      end
      StDly: begin
        stop    = 1'b1;
        state_d = StFetch;
      end
      StSend: begin
        if (rx_WR_enabled) begin
          rx_WR      = 1'b1;
          rx_databus = rpl_word;
          replied_d  = 1'b1;
          idx_d      = idx_q + 1'b1;
          if (last_word) state_d = StFetch;
        end
      end
      StDrop: begin
        skip    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q     <= StIdle;
      payload_q   <= '0;
      words_q     <= '0;
      chan_q      <= '0;
      ts_q        <= '0;
      op_q        <= '0;
      opw_q       <= '0;
      addr_q      <= '0;
      val_q       <= '0;
      mask_q      <= '0;
      rd_busy_q   <= 1'b0;
      rd_cnt_q    <= '0;
      rd_data_q   <= '0;
      replied_q   <= 1'b0;
      idx_q       <= '0;
      stop_time_q <= '0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      words_q     <= words_d;
      chan_q      <= chan_d;
      ts_q        <= ts_d;
      op_q        <= op_d;
      opw_q       <= opw_d;
      addr_q      <= addr_d;
      val_q       <= val_d;
      mask_q      <= mask_d;
      rd_busy_q   <= rd_busy_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_data_q   <= rd_data_d;
      replied_q   <= replied_d;
      idx_q       <= idx_d;
      stop_time_q <= stop_time_d;
    end
  end

`ifdef CMD_STATS_EN
  logic [15:0] stat_exec_q, stat_exec_d;
  logic [15:0] stat_late_q, stat_late_d;
  logic [15:0] stat_err_q, stat_err_d;

  // Drops from TS are bad channels; from FETCH, unknown opcodes or truncation.
  always_comb begin
    stat_exec_d = stat_exec_q;
    stat_late_d = stat_late_q;
    stat_err_d  = stat_err_q;
    if ((state_q == StFetch) && (state_d == StIdle)) stat_exec_d = sat_inc16(stat_exec_q);
    if ((state_q == StWait) && (state_d == StDrop)) stat_late_d = sat_inc16(stat_late_q);
    if (((state_q == StTs) || (state_q == StFetch)) && (state_d == StDrop)) begin
      stat_err_d = sat_inc16(stat_err_q);
    end
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      stat_exec_q <= '0;
      stat_late_q <= '0;
      stat_err_q  <= '0;
    end else begin
      stat_exec_q <= stat_exec_d;
      stat_late_q <= stat_late_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign stat_exec = stat_exec_q;
  assign stat_late = stat_late_q;
  assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_cmd_dispatch_mc.sv
// Directed bench for cmd_dispatch_mc: show-ahead FIFO model, register bus with
// fixed read latency, and event monitors sampled on the falling edge.
module tb_cmd_dispatch_mc;

  localparam int unsigned RdLat = 3;

  logic        txclk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] adc_time = 32'd0;
  logic        pkt_waiting = 1'b0;
  logic [31:0] fifodata = 32'd0;
  logic        rdreq, skip, rx_WR, rx_WR_done, reg_we, reg_re, stop;
  logic        rx_WR_enabled = 1'b1;
  logic [15:0] rx_databus, stop_time;
  logic [1:0]  reg_chan;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [31:0] rd_value = 32'd0;
  logic [2:0]  re_pipe = 3'd0;

  always #5 txclk = ~txclk;

  cmd_dispatch_mc #(
    .NUM_CHAN  (4),
    .ADDR_W    (7),
    .JITTER    (5),
    .PAYLOAD_W (7),
    .REG_RD_LAT(RdLat)
  ) dut (
    .txclk        (txclk),
    .reset        (reset),
    .adc_time     (adc_time),
    .pkt_waiting  (pkt_waiting),
    .fifodata     (fifodata),
    .rdreq        (rdreq),
    .skip         (skip),
    .rx_WR_enabled(rx_WR_enabled),
    .rx_databus   (rx_databus),
    .rx_WR        (rx_WR),
    .rx_WR_done   (rx_WR_done),
    .reg_chan     (reg_chan),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .stop         (stop),
    .stop_time    (stop_time)
  );

  // Register bus: data valid only exactly RdLat cycles after the strobe.
  always @(posedge txclk) re_pipe <= {re_pipe[1:0], reg_re};
  assign reg_rdata = re_pipe[RdLat-1] ? rd_value : 32'hBAD0_BAD0;

  logic [31:0] fifo[$];
  always @(posedge txclk) begin
    if (rdreq && (fifo.size() != 0)) void'(fifo.pop_front());
    if (skip) fifo.delete();
    pkt_waiting <= (fifo.size() != 0);
    fifodata    <= (fifo.size() != 0) ? fifo[0] : 32'd0;
  end

  int n_we = 0, n_re = 0, n_both = 0, n_skip = 0, n_wr = 0, n_done = 0, n_stop = 0, n_pop = 0;
  logic [1:0]  we_chan;
  logic [6:0]  we_addr, re_addr;
  logic [31:0] we_data;
  logic [15:0] stop_val;
  logic [15:0] rx_q[$];

  always @(negedge txclk) begin
    if (reg_we) begin
      n_we++;
      we_chan = reg_chan;
      we_addr = reg_addr;
      we_data = reg_wdata;
    end
    if (reg_re) begin
      n_re++;
      re_addr = reg_addr;
    end
    if (reg_we && reg_re) n_both++;
    if (skip) n_skip++;
    if (rx_WR) begin
      n_wr++;
      rx_q.push_back(rx_databus);
    end
    if (rx_WR_done) n_done++;
    if (stop) begin
      n_stop++;
      stop_val = stop_time;
    end
    if (rdreq) n_pop++;
  end

  int tests = 0, fails = 0;
  int s_we, s_re, s_skip, s_wr, s_done, s_stop, s_pop;

  task automatic snap();
    s_we = n_we; s_re = n_re; s_skip = n_skip; s_wr = n_wr;
    s_done = n_done; s_stop = n_stop; s_pop = n_pop;
  endtask

  function automatic logic [31:0] hdr(input int unsigned payload, input int unsigned chan);
    logic [31:0] h;
    h = 32'd0;
    h[8:2]   = payload[6:0];
    h[20:16] = chan[4:0];
    return h;
  endfunction

  task automatic drive_cycle();
    @(posedge txclk);
    #1;
  endtask

  task automatic wait_skip(input string name);
    int k;
    k = 0;
    while ((n_skip == s_skip) && (k < 80)) begin
      @(negedge txclk);
      k++;
    end
    repeat (2) @(negedge txclk);
    tests++;
    if (n_skip - s_skip !== 1) begin
      fails++;
      $display("FAIL %s skip_count: got %0d required 1", name, n_skip - s_skip);
    end
  endtask

  task automatic test_reset();
    logic [79:0] outs;
    reset = 1'b1;
    repeat (3) drive_cycle();
    @(negedge txclk);
    outs = {rdreq, skip, rx_WR, rx_WR_done, rx_databus, reg_chan, reg_addr, reg_wdata,
            reg_we, reg_re, stop, stop_time};
    tests++;
    if (outs !== 80'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    drive_cycle();
    reset = 1'b0;
    drive_cycle();
  endtask

  task automatic test_write();
    drive_cycle();
    snap();
    adc_time = 32'd1000;
    fifo.push_back(hdr(2, 1));
    fifo.push_back(32'd1003);
    fifo.push_back({8'd2, 24'd5});
    fifo.push_back(32'hDEAD_BEEF);
    wait_skip("write");
    tests++; if (n_we - s_we !== 1) begin fails++; $display("FAIL write_we_count: got %0d required 1", n_we - s_we); end
    tests++; if (we_chan !== 2'd1) begin fails++; $display("FAIL write_chan: got %0d required 1", we_chan); end
    tests++; if (we_addr !== 7'd5) begin fails++; $display("FAIL write_addr: got %0d required 5", we_addr); end
    tests++; if (we_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL write_data: got %h required deadbeef", we_data); end
    tests++; if ((n_wr - s_wr) + (n_done - s_done) + (n_re - s_re) !== 0) begin
      fails++; $display("FAIL write_no_reply: got %0d events required 0", (n_wr - s_wr) + (n_done - s_done) + (n_re - s_re));
    end
  endtask

  task automatic test_late_and_wrap();
    drive_cycle();
    snap();
    adc_time = 32'd5000;
    fifo.push_back(hdr(2, 0));
    fifo.push_back(32'd4999);
    fifo.push_back({8'd2, 24'd1});
    fifo.push_back(32'h1111_1111);
    wait_skip("late_neg");
    tests++; if ((n_we - s_we) + (n_re - s_re) !== 0) begin fails++; $display("FAIL late_neg_strobes: got %0d required 0", (n_we - s_we) + (n_re - s_re)); end
    drive_cycle();
    snap();
    fifo.push_back(hdr(2, 0));
    fifo.push_back(32'd5000);
    fifo.push_back({8'd2, 24'd1});
    fifo.push_back(32'h2222_2222);
    wait_skip("late_zero");
    tests++; if (n_we - s_we !== 0) begin fails++; $display("FAIL late_zero_we: got %0d required 0", n_we - s_we); end
    drive_cycle();
    snap();
    adc_time = 32'hFFFF_FFFE;
    fifo.push_back(hdr(2, 3));
    fifo.push_back(32'h0000_0002);
    fifo.push_back({8'd2, 24'd7});
    fifo.push_back(32'h3333_4444);
    wait_skip("wrap");
    tests++; if (n_we - s_we !== 1) begin fails++; $display("FAIL wrap_we_count: got %0d required 1", n_we - s_we); end
    tests++; if (we_data !== 32'h3333_4444) begin fails++; $display("FAIL wrap_data: got %h required 33334444", we_data); end
  endtask

  task automatic test_hold();
    drive_cycle();
    snap();
    adc_time = 32'd1000;
    fifo.push_back(hdr(2, 2));
    fifo.push_back(32'd1020);
    fifo.push_back({8'd2, 24'd9});
    fifo.push_back(32'h5555_AAAA);
    repeat (12) drive_cycle();
    @(negedge txclk);
    tests++; if ((n_we - s_we) + (n_skip - s_skip) !== 0) begin
      fails++; $display("FAIL hold_early: got %0d events required 0", (n_we - s_we) + (n_skip - s_skip));
    end
    adc_time = 32'd1018;
    wait_skip("hold");
    tests++; if ((n_we - s_we !== 1) || (we_data !== 32'h5555_AAAA)) begin
      fails++; $display("FAIL hold_exec: got %0d writes data %h required 1 5555aaaa", n_we - s_we, we_data);
    end
  endtask

  task automatic test_read_stall();
    logic [15:0] exp[4];
    int          base;
    drive_cycle();
    snap();
    base          = rx_q.size();
    rx_WR_enabled = 1'b0;
    rd_value      = 32'h1234_5678;
    adc_time      = 32'd2000;
    fifo.push_back(hdr(1, 2));
    fifo.push_back(32'd2002);
    fifo.push_back(32'h0400_1289);
    repeat (25) drive_cycle();
    @(negedge txclk);
    tests++; if (n_wr - s_wr !== 0) begin fails++; $display("FAIL read_stall_wr: got %0d required 0", n_wr - s_wr); end
    tests++; if ((n_re - s_re !== 1) || (re_addr !== 7'd9)) begin
      fails++; $display("FAIL read_strobe: got %0d reads addr %0d required 1 9", n_re - s_re, re_addr);
    end
    drive_cycle();
    rx_WR_enabled = 1'b1;
    wait_skip("read");
    exp[0] = 16'h0506; exp[1] = 16'h1289; exp[2] = 16'h1234; exp[3] = 16'h5678;
    tests++; if (rx_q.size() - base !== 4) begin fails++; $display("FAIL read_word_count: got %0d required 4", rx_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] got;
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 16'hxxxx;
      tests++;
      if (got !== exp[i]) begin fails++; $display("FAIL read_word%0d: got %h required %h", i, got, exp[i]); end
    end
    tests++; if (n_done - s_done !== 1) begin fails++; $display("FAIL read_done: got %0d required 1", n_done - s_done); end
  endtask

  task automatic test_masked();
    drive_cycle();
    snap();
    rd_value = 32'hFFFF_0000;
    adc_time = 32'd3000;
    fifo.push_back(hdr(3, 0));
    fifo.push_back(32'd3001);
    fifo.push_back({8'd3, 24'd3});
    fifo.push_back(32'h0000_ABCD);
    fifo.push_back(32'h0000_00FF);
    wait_skip("masked");
    tests++; if ((n_re - s_re !== 1) || (n_we - s_we !== 1)) begin
      fails++; $display("FAIL masked_strobes: got re %0d we %0d required 1 1", n_re - s_re, n_we - s_we);
    end
    tests++; if (we_data !== 32'hFFFF_00CD) begin fails++; $display("FAIL masked_data: got %h required ffff00cd", we_data); end
    tests++; if (we_addr !== 7'd3) begin fails++; $display("FAIL masked_addr: got %0d required 3", we_addr); end
  endtask

  task automatic test_errors();
    int base;
    drive_cycle();
    snap();
    base     = rx_q.size();
    adc_time = 32'd4000;
    fifo.push_back(hdr(2, 1));
    fifo.push_back(32'hFFFF_FFFF);
    fifo.push_back(32'h0000_0042);
    fifo.push_back({8'd2, 24'd4});
    wait_skip("trunc");
    tests++; if ((n_we - s_we) + (n_done - s_done) !== 0) begin
      fails++; $display("FAIL trunc_no_write: got %0d events required 0", (n_we - s_we) + (n_done - s_done));
    end
    tests++; if ((rx_q.size() - base !== 2) || (rx_q[base] !== 16'h0102) || (rx_q[base + 1] !== 16'h0042)) begin
      fails++; $display("FAIL ping_reply: got %0d words required 0102 0042", rx_q.size() - base);
    end
    drive_cycle();
    snap();
    fifo.push_back(hdr(1, 0));
    fifo.push_back(32'd4002);
    fifo.push_back(32'h0700_0005);
    wait_skip("unknown_op");
    tests++; if ((n_we - s_we) + (n_re - s_re) + (n_wr - s_wr) !== 0) begin
      fails++; $display("FAIL unknown_op_events: got %0d required 0", (n_we - s_we) + (n_re - s_re) + (n_wr - s_wr));
    end
    drive_cycle();
    snap();
    fifo.push_back(hdr(2, 6));
    fifo.push_back(32'd4003);
    fifo.push_back({8'd2, 24'd1});
    fifo.push_back(32'h7777_7777);
    wait_skip("bad_chan");
    tests++; if ((n_pop - s_pop !== 2) || (n_we - s_we !== 0)) begin
      fails++; $display("FAIL bad_chan: got pops %0d writes %0d required 2 0", n_pop - s_pop, n_we - s_we);
    end
  endtask

  task automatic test_delay();
    drive_cycle();
    snap();
    adc_time = 32'd6000;
    fifo.push_back(hdr(1, 0));
    fifo.push_back(32'd6004);
    fifo.push_back({8'd12, 8'd0, 16'h0123});
    wait_skip("delay");
    tests++; if ((n_stop - s_stop !== 1) || (stop_val !== 16'h0123)) begin
      fails++; $display("FAIL delay_stop: got %0d pulses time %h required 1 0123", n_stop - s_stop, stop_val);
    end
    tests++; if (n_done - s_done !== 0) begin fails++; $display("FAIL delay_done: got %0d required 0", n_done - s_done); end
  endtask

  task automatic test_reset_mid_send();
    logic [79:0] outs;
    drive_cycle();
    snap();
    rx_WR_enabled = 1'b0;
    rd_value      = 32'hCAFE_F00D;
    adc_time      = 32'd7000;
    fifo.push_back(hdr(1, 3));
    fifo.push_back(32'd7002);
    fifo.push_back(32'h0400_0011);
    repeat (25) drive_cycle();
    reset = 1'b1;
    drive_cycle();
    @(negedge txclk);
    outs = {rdreq, skip, rx_WR, rx_WR_done, rx_databus, reg_chan, reg_addr, reg_wdata,
            reg_we, reg_re, stop, stop_time};
    tests++;
    if (outs !== 80'd0) begin fails++; $display("FAIL reset_mid_outputs: got %h required 0", outs); end
    drive_cycle();
    reset         = 1'b0;
    rx_WR_enabled = 1'b1;
    repeat (10) drive_cycle();
    @(negedge txclk);
    tests++; if ((n_wr - s_wr) + (n_done - s_done) + (n_skip - s_skip) !== 0) begin
      fails++; $display("FAIL reset_mid_abandon: got %0d events required 0", (n_wr - s_wr) + (n_done - s_done) + (n_skip - s_skip));
    end
    snap();
    adc_time = 32'd8000;
    fifo.push_back(hdr(2, 2));
    fifo.push_back(32'd8005);
    fifo.push_back({8'd2, 24'd66});
    fifo.push_back(32'h0BAD_CAFE);
    wait_skip("after_reset");
    tests++; if ((n_we - s_we !== 1) || (we_data !== 32'h0BAD_CAFE) || (we_addr !== 7'd66) || (we_chan !== 2'd2)) begin
      fails++; $display("FAIL after_reset_write: got %0d writes %h addr %0d chan %0d required 1 0badcafe 66 2",
                        n_we - s_we, we_data, we_addr, we_chan);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_late_and_wrap();
    test_hold();
    test_read_stall();
    test_masked();
    test_errors();
    test_delay();
    test_reset_mid_send();
    tests++;
    if (n_both !== 0) begin fails++; $display("FAIL we_re_overlap: got %0d required 0", n_both); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
